// File: rtl/timer_pkg.sv
// Shared definitions for the timer counter block.
// Contents: count-direction encodings and the default counter and prescaler-select widths.
package timer_pkg;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV_W = 3;

endpackage

// File: rtl/timer_cnt_flags_if.sv
// Control/status bundle between the APB-side timer registers and timer_cnt_flags.
// master: drives enable, up_down, load, load_value, div_sel, clears and interrupt enables;
//         observes counter, overflow_flag, underflow_flag, irq.
// slave:  the reverse (the counter block itself).
interface timer_cnt_flags_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 3
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [DIV_W-1:0] div_sel;
    logic             clear_ovf;
    logic             clear_udf;
    logic             ovf_ie;
    logic             udf_ie;
    logic [WIDTH-1:0] counter;
    logic             overflow_flag;
    logic             underflow_flag;
    logic             irq;

    modport master (
        output enable, up_down, load, load_value, div_sel,
        output clear_ovf, clear_udf, ovf_ie, udf_ie,
        input  counter, overflow_flag, underflow_flag, irq
    );

    modport slave (
        input  enable, up_down, load, load_value, div_sel,
        input  clear_ovf, clear_udf, ovf_ie, udf_ie,
        output counter, overflow_flag, underflow_flag, irq
    );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler producing a one-cycle count tick every 2^div_sel enabled cycles.
// Ports: pclk, preset_n (async, active-high reset), enable, load, div_sel in; tick out.
// The prescaler restarts from zero whenever the timer is disabled or loaded.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] div_sel,
    output logic             tick
);
    localparam int unsigned PW = (1 << DIV_W) - 1;

    logic          run;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] mask;

    always_comb begin
        run     = enable & ~load;
        presc_d = run ? presc_q + PW'(1) : '0;
        // Low div_sel bits set; an empty mask (div_sel=0) makes every running cycle a tick.
        mask    = ~({PW{1'b1}} << div_sel);
        tick    = run & ((presc_q & mask) == mask);
    end

    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/timer_cnt_flags.sv
// Up/down timer counter with prescaler, sticky overflow/underflow flags and masked irq.
// Ports: pclk, preset_n (async, active-high reset), bus (timer_cnt_flags_if.slave) carrying
//        controls in and counter/flags/irq out.
module timer_cnt_flags
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input logic              pclk,
    input logic              preset_n,
    timer_cnt_flags_if.slave bus
);
    logic             tick;
    logic             ovf_evt, udf_evt;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .pclk     (pclk),
        .preset_n (preset_n),
        .enable   (bus.enable),
        .load     (bus.load),
        .div_sel  (bus.div_sel),
        .tick     (tick)
    );

    always_comb begin
        ovf_evt = tick & ~bus.load & (bus.up_down == CNT_UP) & (counter_q == {WIDTH{1'b1}});
        udf_evt = tick & ~bus.load & (bus.up_down == CNT_DOWN) & (counter_q == '0);

        counter_d = counter_q;
        if (bus.load) begin
            counter_d = bus.load_value;
        end else if (tick) begin
            counter_d = (bus.up_down == CNT_UP) ? counter_q + WIDTH'(1)
                                                : counter_q - WIDTH'(1);
        end

        // A new event outranks a clear in the same cycle so no wrap goes unreported.
        ovf_d = ovf_evt | (ovf_q & ~bus.clear_ovf);
        udf_d = udf_evt | (udf_q & ~bus.clear_udf);
    end

    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            counter_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign bus.counter        = counter_q;
    assign bus.overflow_flag  = ovf_q;
    assign bus.underflow_flag = udf_q;
    assign bus.irq            = (ovf_q & bus.ovf_ie) | (udf_q & bus.udf_ie);

endmodule

// File: tb/tb_timer_cnt_flags.sv
// Directed bench for timer_cnt_flags: an 8-bit instance and a 4-bit instance.
module tb_timer_cnt_flags;

    logic pclk;
    logic preset_n;

    int vecs;
    int errs;

    timer_cnt_flags_if #(.WIDTH(8), .DIV_W(3)) bus_a ();
    timer_cnt_flags_if #(.WIDTH(4), .DIV_W(3)) bus_b ();

    timer_cnt_flags #(.WIDTH(8), .DIV_W(3)) u_dut_a (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus_a)
    );

    timer_cnt_flags #(.WIDTH(4), .DIV_W(3)) u_dut_b (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        bus_a.enable     = 1'b0;
        bus_a.load       = 1'b1;
        bus_a.load_value = v;
        step(1);
        bus_a.load       = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        preset_n = 1'b1;
        bus_a.enable = 0; bus_a.up_down = 0; bus_a.load = 0; bus_a.load_value = '0;
        bus_a.div_sel = '0; bus_a.clear_ovf = 0; bus_a.clear_udf = 0;
        bus_a.ovf_ie = 0; bus_a.udf_ie = 0;
        bus_b.enable = 0; bus_b.up_down = 0; bus_b.load = 0; bus_b.load_value = '0;
        bus_b.div_sel = '0; bus_b.clear_ovf = 0; bus_b.clear_udf = 0;
        bus_b.ovf_ie = 0; bus_b.udf_ie = 0;

        step(2);
        chk("rst_counter", 32'(bus_a.counter), 32'h0);
        chk("rst_irq", 32'(bus_a.irq), 32'h0);
        preset_n = 1'b0;

        // Reset mid-count is asynchronous.
        load_a(8'h5A);
        chk("load_5a", 32'(bus_a.counter), 32'h5A);
        bus_a.enable = 1'b1;
        #2;
        preset_n = 1'b1;
        #1;
        chk("async_rst_counter", 32'(bus_a.counter), 32'h0);
        chk("async_rst_ovf", 32'(bus_a.overflow_flag), 32'h0);
        chk("async_rst_udf", 32'(bus_a.underflow_flag), 32'h0);
        step(1);
        chk("rst_hold_counter", 32'(bus_a.counter), 32'h0);
        bus_a.enable = 1'b0;
        preset_n = 1'b0;

        // Overflow wrap FE -> FF -> 00.
        bus_a.ovf_ie = 1'b1;
        load_a(8'hFE);
        chk("ovf_load", 32'(bus_a.counter), 32'hFE);
        bus_a.enable = 1'b1;
        step(1);
        chk("ovf_ff", 32'(bus_a.counter), 32'hFF);
        chk("ovf_flag_pre", 32'(bus_a.overflow_flag), 32'h0);
        step(1);
        chk("ovf_wrap", 32'(bus_a.counter), 32'h00);
        chk("ovf_flag", 32'(bus_a.overflow_flag), 32'h1);
        chk("ovf_irq", 32'(bus_a.irq), 32'h1);
        chk("ovf_udf_clear", 32'(bus_a.underflow_flag), 32'h0);
        bus_a.enable = 1'b0;
        step(2);
        chk("ovf_sticky", 32'(bus_a.overflow_flag), 32'h1);
        bus_a.clear_ovf = 1'b1;
        step(1);
        bus_a.clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(bus_a.overflow_flag), 32'h0);
        chk("ovf_irq_off", 32'(bus_a.irq), 32'h0);

        // Underflow wrap 01 -> 00 -> FF.
        bus_a.udf_ie = 1'b1;
        bus_a.up_down = 1'b1;
        load_a(8'h01);
        bus_a.enable = 1'b1;
        step(1);
        chk("udf_00", 32'(bus_a.counter), 32'h00);
        chk("udf_flag_pre", 32'(bus_a.underflow_flag), 32'h0);
        step(1);
        chk("udf_wrap", 32'(bus_a.counter), 32'hFF);
        chk("udf_flag", 32'(bus_a.underflow_flag), 32'h1);
        chk("udf_irq", 32'(bus_a.irq), 32'h1);
        chk("udf_ovf_clear", 32'(bus_a.overflow_flag), 32'h0);
        bus_a.enable = 1'b0;
        bus_a.clear_ovf = 1'b1;
        step(1);
        bus_a.clear_ovf = 1'b0;
        chk("clr_ovf_keeps_udf", 32'(bus_a.underflow_flag), 32'h1);
        bus_a.clear_udf = 1'b1;
        step(1);
        bus_a.clear_udf = 1'b0;
        chk("udf_cleared", 32'(bus_a.underflow_flag), 32'h0);
        chk("udf_irq_off", 32'(bus_a.irq), 32'h0);
        chk("udf_hold_ff", 32'(bus_a.counter), 32'hFF);

        // Prescaler: divide by 4.
        bus_a.up_down = 1'b0;
        bus_a.div_sel = 3'd2;
        load_a(8'h00);
        bus_a.enable = 1'b1;
        step(3);
        chk("psc_cyc3", 32'(bus_a.counter), 32'h0);
        step(1);
        chk("psc_cyc4", 32'(bus_a.counter), 32'h1);
        step(3);
        chk("psc_cyc7", 32'(bus_a.counter), 32'h1);
        step(1);
        chk("psc_cyc8", 32'(bus_a.counter), 32'h2);
        // Disable part-way through a period; the period must restart in full.
        step(2);
        bus_a.enable = 1'b0;
        step(3);
        chk("psc_disabled", 32'(bus_a.counter), 32'h2);
        bus_a.enable = 1'b1;
        step(3);
        chk("psc_restart3", 32'(bus_a.counter), 32'h2);
        step(1);
        chk("psc_restart4", 32'(bus_a.counter), 32'h3);
        bus_a.enable = 1'b0;

        // Load beats a wrapping tick.
        bus_a.div_sel = 3'd0;
        load_a(8'hFF);
        bus_a.enable = 1'b1;
        bus_a.load = 1'b1;
        bus_a.load_value = 8'h10;
        step(1);
        bus_a.load = 1'b0;
        bus_a.enable = 1'b0;
        chk("prio_load", 32'(bus_a.counter), 32'h10);
        chk("prio_no_ovf", 32'(bus_a.overflow_flag), 32'h0);

        // Overflow event and clear together: set wins.
        load_a(8'hFF);
        bus_a.enable = 1'b1;
        bus_a.clear_ovf = 1'b1;
        step(1);
        bus_a.clear_ovf = 1'b0;
        bus_a.enable = 1'b0;
        chk("setwin_counter", 32'(bus_a.counter), 32'h00);
        chk("setwin_flag", 32'(bus_a.overflow_flag), 32'h1);

        // 4-bit instance: masked overflow, then unmask combinationally.
        bus_b.load = 1'b1;
        bus_b.load_value = 4'hF;
        step(1);
        bus_b.load = 1'b0;
        chk("w4_load", 32'(bus_b.counter), 32'hF);
        bus_b.enable = 1'b1;
        step(1);
        bus_b.enable = 1'b0;
        chk("w4_wrap", 32'(bus_b.counter), 32'h0);
        chk("w4_ovf", 32'(bus_b.overflow_flag), 32'h1);
        chk("w4_irq_masked", 32'(bus_b.irq), 32'h0);
        bus_b.ovf_ie = 1'b1;
        #1;
        chk("w4_irq_unmasked", 32'(bus_b.irq), 32'h1);
        chk("w4_udf", 32'(bus_b.underflow_flag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
